ecap5_wbuart_bridge: RTL
========================

# ecap5_wbuart_bridge

UART-controlled Wishbone master for debug/bring-up access to the ECAP5 bus. Receives 8N1 command frames on `uart_rx_i`, issues single 32-bit pipelined Wishbone B4 read or write cycles as bus initiator, and returns data or status bytes on `uart_tx_o`. Sits at top level beside the processor as a second bus master, ahead of the interconnect arbiter.

## Interface
- CLK_PER_BIT, default 868: clock cycles per UART bit (100 MHz / 115200 baud); minimum 8.
- WB_TIMEOUT, default 1024: cycles allowed from first `wb_stb_o` assertion to `wb_ack_i`.
- clk_i  in  1  system clock; all logic on rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- wb_adr_o  out  32  Wishbone address.
- wb_dat_o  out  32  write data.
- wb_dat_i  in  32  read data, valid with `wb_ack_i`.
- wb_we_o  out  1  1 = write.
- wb_sel_o  out  4  byte selects; always 4'hF during a cycle, 4'h0 otherwise.
- wb_stb_o  out  1  strobe.
- wb_ack_i  in  1  slave acknowledge.
- wb_cyc_o  out  1  bus cycle.
- wb_stall_i  in  1  slave stall.
- uart_rx_i  in  1  serial input, asynchronous.
- uart_tx_o  out  1  serial output, idle high.

## Operation
- Frames: 8N1, LSB first. Multi-byte fields little-endian.
- Commands: 0x01 write = cmd, 4 addr bytes, 4 data bytes -> response 0xA5. 0x02 read = cmd, 4 addr bytes -> response 4 data bytes. Any other cmd byte -> response 0xEE, no bus access.
- RX: 2-flop synchronizer on `uart_rx_i`; falling edge in idle starts a frame; each bit sampled at mid-bit (CLK_PER_BIT/2 after start edge, then every CLK_PER_BIT). Start bit re-checked at mid-point; if high, false start, back to idle. Stop bit sampled low = framing error: byte discarded, parser forced to IDLE. RX re-arms right after stop sample.
- Parser FSM: IDLE -> ADDR (4 bytes) -> DATA (4 bytes, write only) -> BUS_REQ -> BUS_WAIT -> RESP -> IDLE. Unknown cmd: IDLE -> RESP with 0xEE.
- BUS_REQ: `wb_cyc_o`=`wb_stb_o`=1, adr/we/dat/sel driven; `wb_stb_o` drops the cycle after a cycle with `wb_stall_i`=0.
- BUS_WAIT: `wb_cyc_o` held until `wb_ack_i`. Ack in the same cycle as the accepted strobe is valid. Read data latched on ack cycle. `wb_cyc_o` drops the cycle after ack.
- Timeout: counter starts at first `wb_stb_o`; at WB_TIMEOUT cycles without ack, `wb_cyc_o`/`wb_stb_o` drop, response 0xEE. Late acks ignored.
- Bytes received in BUS_REQ, BUS_WAIT, RESP are dropped.
- TX: shifts response bytes back-to-back, 1 stop bit each, no inter-byte gap. FSM returns to IDLE after last stop bit completes.

## Timing
- Reset values: `uart_tx_o`=1, `wb_cyc_o`=0, `wb_stb_o`=0, `wb_we_o`=0, `wb_sel_o`=0, `wb_adr_o`=0, `wb_dat_o`=0; FSM IDLE, RX idle, counters 0.
- RX byte valid the cycle after stop-bit mid-sample (3 cycles synchronizer+detect latency from pin edge to start counting).
- `wb_cyc_o`/`wb_stb_o` rise 1 cycle after last command byte valid.
- Response start bit on `uart_tx_o` 1 cycle after ack (or timeout, or unknown cmd byte valid).
- Each TX bit lasts exactly CLK_PER_BIT cycles.
- Reset mid-frame or mid-bus-cycle: immediate (async) return to reset values; `wb_cyc_o` drops without waiting for ack.

## Test plan
- CLK_PER_BIT=16. Send 01, 10 00 00 00, EF BE AD DE; slave acks 1 cycle after strobe -> one cycle adr=0x00000010, dat=0xDEADBEEF, we=1, sel=F; TX returns 0xA5.
- Send 02, 20 00 00 00; slave stalls 3 cycles then returns 0x12345678 -> stb held 4 cycles, cyc until ack; TX returns 78 56 34 12.
- Read with no ack, WB_TIMEOUT=32 -> cyc/stb drop after 32 cycles; TX returns 0xEE; late ack ignored.
- Send 0x7F -> no bus activity, TX returns 0xEE; following valid read command served normally.
- Framing error (stop bit 0) on 3rd address byte -> parser resets; subsequent full write command executes with correct address.
- Assert rst_i during BUS_WAIT and mid-TX byte -> all outputs at reset values within the same cycle; next command served normally.

Source files
------------

// File: rtl/ecap5_wbuart_bridge.sv
// ecap5_wbuart_bridge: UART-driven single-beat Wishbone B4 pipelined master.
// 8N1 command frames in on uart_rx_i, one 32-bit read or write on the bus,
// status or read data shifted back out on uart_tx_o.
module ecap5_wbuart_bridge #(
  parameter int CLK_PER_BIT = 868,
  parameter int WB_TIMEOUT  = 1024
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  output logic        wb_we_o,
  output logic [3:0]  wb_sel_o,
  output logic        wb_stb_o,
  input  logic        wb_ack_i,
  output logic        wb_cyc_o,
  input  logic        wb_stall_i,
  input  logic        uart_rx_i,
  output logic        uart_tx_o
);

  localparam int CW = $clog2(CLK_PER_BIT);
  localparam int TW = (WB_TIMEOUT > 1) ? $clog2(WB_TIMEOUT) : 1;
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLK_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLK_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(WB_TIMEOUT - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {P_IDLE, P_ADDR, P_DATA, P_BUS_REQ, P_BUS_WAIT, P_RESP} p_state_t;

  rx_state_t       rx_state;
  logic            rx_s1, rx_s2, rx_prev;
  logic [CW-1:0]   rx_cnt;
  logic [2:0]      rx_bit;
  logic [7:0]      rx_shift;
  logic [7:0]      rx_byte;
  logic            rx_valid;
  logic            rx_ferr;

  p_state_t        state;
  logic [1:0]      byte_cnt;
  logic            cmd_we;
  logic [TW-1:0]   tcnt;
  logic [31:0]     resp_data;
  logic [2:0]      resp_left;
  logic [CW-1:0]   tx_cnt;
  logic [3:0]      tx_bit;
  logic            ack_ok;

  // An ack counts only once the strobe has been accepted (this cycle or earlier).
  assign ack_ok = wb_ack_i && ((state == P_BUS_WAIT) || (state == P_BUS_REQ && !wb_stall_i));

  // RX: synchronize, detect start edge, sample each bit at its midpoint.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_prev  <= 1'b1;
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
      rx_byte  <= '0;
      rx_valid <= 1'b0;
      rx_ferr  <= 1'b0;
    end else begin
      rx_s1    <= uart_rx_i;
      rx_s2    <= rx_s1;
      rx_prev  <= rx_s2;
      rx_valid <= 1'b0;
      rx_ferr  <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          if (rx_prev && !rx_s2) begin
            rx_state <= RX_START;
            rx_cnt   <= HALF_LAST;
          end
        end
        RX_START: begin
          if (rx_cnt != '0) begin
            rx_cnt <= rx_cnt - CW'(1);
          end else if (rx_s2) begin
            rx_state <= RX_IDLE;  // glitch, not a real start bit
          end else begin
            rx_state <= RX_DATA;
            rx_cnt   <= BIT_LAST;
            rx_bit   <= '0;
          end
        end
        RX_DATA: begin
          if (rx_cnt != '0) begin
            rx_cnt <= rx_cnt - CW'(1);
          end else begin
            rx_shift <= {rx_s2, rx_shift[7:1]};
            rx_cnt   <= BIT_LAST;
            rx_bit   <= rx_bit + 3'd1;
            if (rx_bit == 3'd7) rx_state <= RX_STOP;
          end
        end
        default: begin
          if (rx_cnt != '0) begin
            rx_cnt <= rx_cnt - CW'(1);
          end else begin
            rx_state <= RX_IDLE;
            if (rx_s2) begin
              rx_byte  <= rx_shift;
              rx_valid <= 1'b1;
            end else begin
              rx_ferr  <= 1'b1;
            end
          end
        end
      endcase
    end
  end

  // Command parser, bus master and response transmitter in one registered FSM.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= P_IDLE;
      byte_cnt  <= '0;
      cmd_we    <= 1'b0;
      tcnt      <= '0;
      resp_data <= '0;
      resp_left <= '0;
      tx_cnt    <= '0;
      tx_bit    <= '0;
      uart_tx_o <= 1'b1;
      wb_adr_o  <= '0;
      wb_dat_o  <= '0;
      wb_we_o   <= 1'b0;
      wb_sel_o  <= 4'h0;
      wb_stb_o  <= 1'b0;
      wb_cyc_o  <= 1'b0;
    end else begin
      case (state)
        P_IDLE: begin
          if (rx_valid) begin
            byte_cnt <= '0;
            if (rx_byte == 8'h01 || rx_byte == 8'h02) begin
              cmd_we <= (rx_byte == 8'h01);
              state  <= P_ADDR;
            end else begin
              resp_data <= 32'h0000_00EE;
              resp_left <= 3'd1;
              uart_tx_o <= 1'b0;
              tx_cnt    <= BIT_LAST;
              tx_bit    <= '0;
              state     <= P_RESP;
            end
          end
        end
        P_ADDR, P_DATA: begin
          if (rx_ferr) begin
            state <= P_IDLE;
          end else if (rx_valid) begin
            byte_cnt <= byte_cnt + 2'd1;
            if (state == P_ADDR) wb_adr_o <= {rx_byte, wb_adr_o[31:8]};
            else                 wb_dat_o <= {rx_byte, wb_dat_o[31:8]};
            if (byte_cnt == 2'd3) begin
              if (state == P_ADDR && cmd_we) begin
                state <= P_DATA;
              end else begin
                state    <= P_BUS_REQ;
                wb_cyc_o <= 1'b1;
                wb_stb_o <= 1'b1;
                wb_sel_o <= 4'hF;
                wb_we_o  <= cmd_we;
                tcnt     <= '0;
              end
            end
          end
        end
        P_BUS_REQ, P_BUS_WAIT: begin
          tcnt <= tcnt + TW'(1);
          if (state == P_BUS_REQ && !wb_stall_i) begin
            wb_stb_o <= 1'b0;
            state    <= P_BUS_WAIT;
          end
          if (ack_ok || tcnt == TMO_LAST) begin
            wb_cyc_o  <= 1'b0;
            wb_stb_o  <= 1'b0;
            wb_we_o   <= 1'b0;
            wb_sel_o  <= 4'h0;
            uart_tx_o <= 1'b0;
            tx_cnt    <= BIT_LAST;
            tx_bit    <= '0;
            state     <= P_RESP;
            if (!ack_ok) begin
              resp_data <= 32'h0000_00EE;
              resp_left <= 3'd1;
            end else if (cmd_we) begin
              resp_data <= 32'h0000_00A5;
              resp_left <= 3'd1;
            end else begin
              resp_data <= wb_dat_i;
              resp_left <= 3'd4;
            end
          end
        end
        default: begin
          // tx_bit: 0 = start bit on the line, 1..8 = data bit tx_bit-1, 9 = stop bit
          if (tx_cnt != '0) begin
            tx_cnt <= tx_cnt - CW'(1);
          end else begin
            tx_cnt <= BIT_LAST;
            if (tx_bit <= 4'd7) begin
              uart_tx_o <= resp_data[tx_bit[2:0]];
              tx_bit    <= tx_bit + 4'd1;
            end else if (tx_bit == 4'd8) begin
              uart_tx_o <= 1'b1;
              tx_bit    <= 4'd9;
            end else if (resp_left > 3'd1) begin
              resp_data <= {8'h00, resp_data[31:8]};
              resp_left <= resp_left - 3'd1;
              uart_tx_o <= 1'b0;
              tx_bit    <= '0;
            end else begin
              state <= P_IDLE;
            end
          end
        end
      endcase
    end
  end

endmodule
